// File: rtl/spi_cs_sequencer_pkg.sv
// Shared types and helpers for the chip-select sequencer and its SPI master.
package spi_cs_sequencer_pkg;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ISSUE,
    ST_WAIT_RX,
    ST_WAIT_RDY,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_e;

  // SPI link settings shared with spi_master.
  localparam int SPI_MODE          = 3;
  localparam int CLKS_PER_HALF_BIT = 4;

  // Width of a byte counter able to hold 0..max_bytes.
  function automatic int count_width(input int max_bytes);
    return $clog2(max_bytes + 1);
  endfunction

  // Width of a down-counter that must hold (largest delay - 1).
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/spi_cs_sequencer_timer.sv
// Loadable down-counter with a done flag; one instance times the setup,
// hold and gap phases of a chip-select frame.
module spi_cs_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and park at zero.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done once the loaded delay has fully elapsed.
  assign done = (cnt_q == '0);

endmodule

// File: rtl/spi_cs_sequencer.sv
// Groups upstream bytes into chip-select framed transactions for spi_master
// and returns each received byte tagged with its index in the frame.
module spi_cs_sequencer
  import spi_cs_sequencer_pkg::*;
#(
  parameter int MAX_BYTES_PER_CS = 2,
  parameter int CS_SETUP_CLKS    = 2,
  parameter int CS_HOLD_CLKS     = 2,
  parameter int CS_GAP_CLKS      = 2,
  localparam int CW = count_width(MAX_BYTES_PER_CS)
) (
  input  logic          i_Clk,
  input  logic          i_RST_L,
  input  logic [CW-1:0] i_TX_Count,
  input  logic [7:0]    i_TX_Byte,
  input  logic          i_TX_DV,
  output logic          o_TX_Ready,
  output logic          o_RX_DV,
  output logic [7:0]    o_RX_Byte,
  output logic [CW-1:0] o_RX_Count,
  output logic [7:0]    o_M_TX_Byte,
  output logic          o_M_TX_DV,
  input  logic          i_M_TX_Ready,
  input  logic          i_M_RX_DV,
  input  logic [7:0]    i_M_RX_Byte,
  output logic          o_SPI_CS_n
);

  localparam int TW = timer_width(CS_SETUP_CLKS, CS_HOLD_CLKS, CS_GAP_CLKS);

  // A phase of N cycles loads N-1: the exit decision is taken on the edge
  // after the counter reaches zero, so the registered effect lands N cycles
  // after the edge that started the phase.
  localparam logic [TW-1:0] SETUP_LOAD = TW'(CS_SETUP_CLKS - 1);
  localparam logic [TW-1:0] HOLD_LOAD  = TW'(CS_HOLD_CLKS - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(CS_GAP_CLKS - 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(MAX_BYTES_PER_CS);
  localparam logic [CW-1:0] ONE        = CW'(1);

  state_e        state_q, state_d;
  logic          cs_n_q, cs_n_d;
  logic          m_tx_dv_q, m_tx_dv_d;
  logic [7:0]    m_tx_byte_q, m_tx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [CW-1:0] rx_count_q, rx_count_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          armed_q;

  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_done;
  logic          tx_accept;

  spi_cs_timer #(
    .W (TW)
  ) u_timer (
    .clk      (i_Clk),
    .rst_n    (i_RST_L),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Ready in IDLE (once out of reset for a cycle) and while a frame waits for its next byte.
  assign o_TX_Ready = ((state_q == ST_IDLE) && armed_q) || (state_q == ST_NEXT);
  assign tx_accept  = i_TX_DV && o_TX_Ready;

  // Frame sequencing: next state, output registers and timer control.
  always_comb begin
    state_d     = state_q;
    cs_n_d      = cs_n_q;
    m_tx_dv_d   = 1'b0;
    m_tx_byte_d = m_tx_byte_q;
    rx_dv_d     = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_count_d  = rx_count_q;
    remaining_d = remaining_q;
    idx_d       = idx_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    unique case (state_q)
      ST_IDLE: begin
        // A zero-length request is dropped without touching chip select.
        if (tx_accept && (i_TX_Count != '0)) begin
          m_tx_byte_d = i_TX_Byte;
          remaining_d = (i_TX_Count > MAX_COUNT) ? MAX_COUNT : i_TX_Count;
          idx_d       = '0;
          cs_n_d      = 1'b0;
          tmr_load    = 1'b1;
          tmr_val     = SETUP_LOAD;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        // Issue straight out of setup when the master is ready, so the first
        // byte leaves exactly CS_SETUP_CLKS after chip select falls.
        if (tmr_done) begin
          if (i_M_TX_Ready) begin
            m_tx_dv_d = 1'b1;
            state_d   = ST_WAIT_RX;
          end else begin
            state_d   = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (i_M_TX_Ready) begin
          m_tx_dv_d = 1'b1;
          state_d   = ST_WAIT_RX;
        end
      end
      ST_WAIT_RX: begin
        if (i_M_RX_DV) begin
          rx_dv_d     = 1'b1;
          rx_byte_d   = i_M_RX_Byte;
          rx_count_d  = idx_q;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            tmr_load = 1'b1;
            tmr_val  = HOLD_LOAD;
            state_d  = ST_HOLD;
          end else begin
            // Only advance while bytes remain so the index stays below MAX_BYTES_PER_CS.
            idx_d   = idx_q + ONE;
            state_d = ST_WAIT_RDY;
          end
        end
      end
      ST_WAIT_RDY: begin
        if (i_M_TX_Ready) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (tx_accept) begin
          m_tx_byte_d = i_TX_Byte;
          state_d     = ST_ISSUE;
        end
      end
      ST_HOLD: begin
        if (tmr_done) begin
          cs_n_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = GAP_LOAD;
          state_d  = ST_GAP;
        end
      end
      ST_GAP: begin
        if (tmr_done) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  // State and output registers; a reset mid-frame abandons the frame outright.
  always_ff @(posedge i_Clk) begin
    if (!i_RST_L) begin
      state_q     <= ST_IDLE;
      cs_n_q      <= 1'b1;
      m_tx_dv_q   <= 1'b0;
      m_tx_byte_q <= '0;
      rx_dv_q     <= 1'b0;
      rx_byte_q   <= '0;
      rx_count_q  <= '0;
      remaining_q <= '0;
      idx_q       <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_n_q      <= cs_n_d;
      m_tx_dv_q   <= m_tx_dv_d;
      m_tx_byte_q <= m_tx_byte_d;
      rx_dv_q     <= rx_dv_d;
      rx_byte_q   <= rx_byte_d;
      rx_count_q  <= rx_count_d;
      remaining_q <= remaining_d;
      idx_q       <= idx_d;
      armed_q     <= 1'b1;
    end
  end

  assign o_SPI_CS_n  = cs_n_q;
  assign o_M_TX_DV   = m_tx_dv_q;
  assign o_M_TX_Byte = m_tx_byte_q;
  assign o_RX_DV     = rx_dv_q;
  assign o_RX_Byte   = rx_byte_q;
  assign o_RX_Count  = rx_count_q;

endmodule
